// File: rtl/onchip_ram_burst_slave_pkg.sv
// Shared types and constants for the on-chip RAM burst slave.
// Contents:
//   state_e         - burst FSM state encoding
//   RdLatencyMin/Max - legal READ_LATENCY range
//   rd_latency_ok()  - range check used to select the output pipeline depth
package onchip_ram_burst_slave_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRdBurst = 2'd1,
      StWrBurst = 2'd2
   } state_e;

   localparam int unsigned RdLatencyMin = 1;
   localparam int unsigned RdLatencyMax = 2;

   function automatic bit rd_latency_ok(input int unsigned rl);
      return (rl >= RdLatencyMin) && (rl <= RdLatencyMax);
   endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Inferred single-port RAM with per-byte write enables, a block-wide clock
// enable and a registered (1-cycle) read port. Contents have no reset.
// Ports:
//   clk_i    - clock
//   en_i     - clock enable; 0 holds memory and read register
//   we_i     - write strobe (gated by be_i per byte lane)
//   re_i     - read strobe; loads rdata_o on the next edge
//   addr_i   - word address, must be < DEPTH when we_i/re_i are set
//   be_i     - byte-lane write enables
//   wdata_i  - write data
//   rdata_o  - registered read data, holds between reads
module onchip_ram_core #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned DEPTH     = 6144,
   parameter string       INIT_FILE = "none"
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W/8-1:0]   be_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);

   localparam int unsigned BeW  = DATA_W / 8;
   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Vendor flows preload the array from INIT_FILE through this attribute.
   (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [IdxW-1:0]   idx;

   assign idx = addr_i[IdxW-1:0];

   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         for (int i = 0; i < BeW; i++) begin
            if (be_i[i]) begin
               mem_q[idx][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
      if (en_i && re_i) begin
         rdata_q <= mem_q[idx];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/onchip_ram_burst_slave.sv
// Avalon-MM slave in front of a parametrised on-chip RAM. Supports
// incrementing read/write bursts, read latency 1 or 2 with readdatavalid,
// waitrequest flow control, out-of-range protection and clken/reset_req gating.
// Ports:
//   clk, reset_n                      - clock, async active-low reset
//   address, burstcount               - command address (first beat) and length
//   chipselect, read, write           - command qualifiers (write wins over read)
//   byteenable, writedata             - write beat data and lane enables
//   clken, reset_req                  - block enable = clken & ~reset_req
//   waitrequest                       - command/beat not accepted this cycle
//   readdata, readdatavalid           - read return path
module onchip_ram_burst_slave
   import onchip_ram_burst_slave_pkg::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 13,
   parameter int unsigned DEPTH        = 6144,
   parameter int unsigned BURST_W      = 4,
   parameter int unsigned READ_LATENCY = 1,
   parameter string       INIT_FILE    = "none"
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W-1:0]     writedata,
   input  logic [BURST_W-1:0]    burstcount,
   input  logic                  clken,
   input  logic                  reset_req,
   output logic                  waitrequest,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid
);

   // An out-of-range READ_LATENCY falls back to the direct (latency 1) path.
   localparam bit Rl2 = rd_latency_ok(READ_LATENCY) && (READ_LATENCY == RdLatencyMax);
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return (a == LastAddr) ? '0 : a + ADDR_W'(1);
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (32'(a) < DEPTH);
   endfunction

   logic                 en;
   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [BURST_W-1:0]   remain_q, remain_d;
   logic [BURST_W-1:0]   burst_len;
   logic [ADDR_W-1:0]    beat_addr;
   logic                 issue;
   logic                 wr_beat;
   logic                 beat_ok;
   logic                 ram_we, ram_re;
   logic [DATA_W-1:0]    ram_rdata;

   // First read stage: valid flag plus "force zero" flag that travels with the beat.
   logic                 s1_vld_q, s1_vld_d;
   logic                 s1_zero_q, s1_zero_d;
   logic [DATA_W-1:0]    s1_data;

   assign en        = clken & ~reset_req;
   assign burst_len = (burstcount == '0) ? BURST_W'(1) : burstcount;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remain_d    = remain_q;
      waitrequest = 1'b1;
      issue       = 1'b0;
      wr_beat     = 1'b0;
      beat_addr   = addr_q;
      if (en) begin
         case (state_q)
            StIdle: begin
               waitrequest = 1'b0;
               beat_addr   = address;
               if (chipselect && (write || read)) begin
                  wr_beat  = write;
                  issue    = ~write;
                  addr_d   = addr_inc(address);
                  remain_d = burst_len - BURST_W'(1);
                  if (burst_len > BURST_W'(1)) begin
                     state_d = write ? StWrBurst : StRdBurst;
                  end
               end
            end
            StRdBurst: begin
               issue    = 1'b1;
               addr_d   = addr_inc(addr_q);
               remain_d = remain_q - BURST_W'(1);
               if (remain_q == BURST_W'(1)) begin
                  state_d = StIdle;
               end
            end
            StWrBurst: begin
               waitrequest = 1'b0;
               if (chipselect && write) begin
                  wr_beat  = 1'b1;
                  addr_d   = addr_inc(addr_q);
                  remain_d = remain_q - BURST_W'(1);
                  if (remain_q == BURST_W'(1)) begin
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
      end
   end

   // Out-of-range beats never touch the array; reads of them return zero.
   assign beat_ok = in_range(beat_addr);
   assign ram_we  = wr_beat & beat_ok;
   assign ram_re  = issue & beat_ok;

   onchip_ram_core #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk_i   (clk),
      .en_i    (en),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (beat_addr),
      .be_i    (byteenable),
      .wdata_i (writedata),
      .rdata_o (ram_rdata)
   );

   // With latency 1 this stage drives readdatavalid, so a frozen cycle must drop
   // it to avoid a duplicate pulse. With latency 2 it holds the pending beat.
   always_comb begin
      s1_vld_d  = en ? issue : (Rl2 & s1_vld_q);
      s1_zero_d = s1_zero_q;
      if (en && issue) begin
         s1_zero_d = ~beat_ok;
      end
   end

   // s1_zero_q resets high so readdata reads as zero out of reset without
   // needing a reset on the RAM output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld_q  <= 1'b0;
         s1_zero_q <= 1'b1;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_zero_q <= s1_zero_d;
      end
   end

   assign s1_data = s1_zero_q ? '0 : ram_rdata;

   if (Rl2) begin : g_rl2
      logic              s2_vld_q, s2_vld_d;
      logic [DATA_W-1:0] s2_data_q, s2_data_d;

      always_comb begin
         s2_vld_d  = en & s1_vld_q;
         s2_data_d = s2_data_q;
         if (en && s1_vld_q) begin
            s2_data_d = s1_data;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
         end else begin
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
         end
      end

      assign readdata      = s2_data_q;
      assign readdatavalid = s2_vld_q;
   end else begin : g_rl1
      assign readdata      = s1_data;
      assign readdatavalid = s1_vld_q;
   end

endmodule

// File: tb/tb_onchip_ram_burst_slave.sv
// Directed bench: two instances (read latency 1 and 2) share one stimulus stream;
// a negedge monitor records every readdatavalid beat with its cycle number.
module tb_onchip_ram_burst_slave;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 13;
   localparam int unsigned DEPTH = 6144;
   localparam int unsigned BW    = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] address;
   logic [3:0]    byteenable;
   logic          chipselect, read, write;
   logic [DW-1:0] writedata;
   logic [BW-1:0] burstcount;
   logic          clken, reset_req;

   logic          wr1, wr2, rdv1, rdv2;
   logic [DW-1:0] rd1, rd2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int base  = 0;

   logic [DW-1:0] q1[$];
   logic [DW-1:0] q2[$];
   int            c1[$];
   int            c2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rdv1) begin q1.push_back(rd1); c1.push_back(cyc); end
      if (rdv2) begin q2.push_back(rd2); c2.push_back(cyc); end
   end

   onchip_ram_burst_slave #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BURST_W(BW), .READ_LATENCY(1), .INIT_FILE("none")
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .burstcount(burstcount), .clken(clken), .reset_req(reset_req),
      .waitrequest(wr1), .readdata(rd1), .readdatavalid(rdv1)
   );

   onchip_ram_burst_slave #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BURST_W(BW), .READ_LATENCY(2), .INIT_FILE("none")
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .burstcount(burstcount), .clken(clken), .reset_req(reset_req),
      .waitrequest(wr2), .readdata(rd2), .readdatavalid(rdv2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      q1.delete(); q2.delete(); c1.delete(); c2.delete();
   endtask

   // Called at a negedge; the following posedge accepts the beat.
   task automatic write_single(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      chk("wr_accept_wait", {30'd0, wr1, wr2}, 32'd0);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
      burstcount = 4'd1;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0; byteenable = 4'hF;
   endtask

   task automatic read_start(input logic [AW-1:0] a, input logic [BW-1:0] n);
      clear_q();
      base = cyc;
      chipselect = 1'b1; read = 1'b1; address = a; burstcount = n;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0; burstcount = 4'd1;
   endtask

   // Single read; checks one beat per instance with exact latency.
   task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
      int b0;
      read_start(a, 4'd1);
      b0 = base;
      repeat (4) @(negedge clk);
      chk({tag, "_n1"}, q1.size(), 1);
      chk({tag, "_n2"}, q2.size(), 1);
      chk({tag, "_d1"}, q1[0], exp);
      chk({tag, "_d2"}, q2[0], exp);
      chk({tag, "_t1"}, c1[0], b0 + 1);
      chk({tag, "_t2"}, c2[0], b0 + 2);
   endtask

   initial begin
      reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
      address = '0; byteenable = 4'hF; chipselect = 1'b0; read = 1'b0; write = 1'b0;
      writedata = '0; burstcount = 4'd1;
      repeat (3) @(negedge clk);
      chk("rst_rdv1", {31'd0, rdv1}, 32'd0);
      chk("rst_rdv2", {31'd0, rdv2}, 32'd0);
      chk("rst_rd1", rd1, 32'd0);
      chk("rst_rd2", rd2, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_wait", {30'd0, wr1, wr2}, 32'd0);

      // Full-word write then read back.
      write_single(13'd5, 32'hDEADBEEF, 4'hF);
      read_check("single", 13'd5, 32'hDEADBEEF);
      chk("hold_rdv", {30'd0, rdv1, rdv2}, 32'd0);
      chk("hold_rd1", rd1, 32'hDEADBEEF);
      chk("hold_rd2", rd2, 32'hDEADBEEF);

      // Partial byte-lane write.
      write_single(13'd5, 32'h0000AAAA, 4'b0011);
      read_check("bytelane", 13'd5, 32'hDEADAAAA);

      // Write burst of 4 across the wrap point; later beats ignore address.
      chipselect = 1'b1; write = 1'b1; burstcount = 4'd4; byteenable = 4'hF;
      address = 13'(DEPTH - 2);
      for (int i = 0; i < 4; i++) begin
         writedata = 32'(i + 1);
         #1 chk("wburst_wait", {31'd0, wr1}, 32'd0);
         @(negedge clk);
         address = 13'd0;
      end
      chipselect = 1'b0; write = 1'b0; burstcount = 4'd1;

      // Read burst of 4 across the wrap point.
      read_start(13'(DEPTH - 2), 4'd4);
      for (int i = 1; i <= 3; i++) begin
         #1 chk("rburst_wait_hi", {30'd0, wr1, wr2}, 32'd3);
         @(negedge clk);
      end
      #1 chk("rburst_wait_lo", {30'd0, wr1, wr2}, 32'd0);
      repeat (4) @(negedge clk);
      chk("rburst_n1", q1.size(), 4);
      chk("rburst_n2", q2.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("rburst_d1", q1[i], 32'(i + 1));
         chk("rburst_d2", q2[i], 32'(i + 1));
         chk("rburst_t2", c2[i], base + 2 + i);
      end

      // Write burst of 8 at 100 for the freeze and reset tests.
      chipselect = 1'b1; write = 1'b1; burstcount = 4'd8; address = 13'd100;
      for (int i = 0; i < 8; i++) begin
         writedata = 32'h100 + 32'(i);
         @(negedge clk);
      end
      chipselect = 1'b0; write = 1'b0; burstcount = 4'd1;

      // Read burst of 8 with clken low for 3 cycles after beat 2 is issued.
      read_start(13'd100, 4'd8);
      @(negedge clk);
      @(negedge clk);
      clken = 1'b0;
      #1 chk("freeze_wait", {30'd0, wr1, wr2}, 32'd3);
      repeat (3) @(negedge clk);
      clken = 1'b1;
      repeat (10) @(negedge clk);
      chk("freeze_n1", q1.size(), 8);
      chk("freeze_n2", q2.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("freeze_d1", q1[i], 32'h100 + 32'(i));
         chk("freeze_d2", q2[i], 32'h100 + 32'(i));
      end
      chk("freeze_t1_b2", c1[2], base + 3);
      chk("freeze_t1_b3", c1[3], base + 7);
      chk("freeze_t1_b7", c1[7], base + 11);
      chk("freeze_t2_b2", c2[2], base + 7);
      chk("freeze_t2_b7", c2[7], base + 12);

      // reset_req gates the block like clken.
      reset_req = 1'b1;
      #1 chk("rreq_wait", {30'd0, wr1, wr2}, 32'd3);
      @(negedge clk);
      reset_req = 1'b0;
      #1 chk("rreq_release", {30'd0, wr1, wr2}, 32'd0);

      // Out-of-range read returns zero; out-of-range write is dropped.
      read_check("oor_rd", 13'(DEPTH), 32'd0);
      write_single(13'(DEPTH), 32'hFFFFFFFF, 4'hF);
      read_check("oor_wr_word0", 13'd0, 32'd3);

      // Async reset in the middle of a read burst of 8.
      read_start(13'd100, 4'd8);
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_rdv", {30'd0, rdv1, rdv2}, 32'd0);
      chk("mid_rst_rd1", rd1, 32'd0);
      chk("mid_rst_rd2", rd2, 32'd0);
      chk("mid_rst_n1", q1.size(), 3);
      chk("mid_rst_n2", q2.size(), 2);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("mid_rst_wait", {30'd0, wr1, wr2}, 32'd0);
      repeat (12) @(negedge clk);
      chk("post_rst_n1", q1.size(), 3);
      chk("post_rst_n2", q2.size(), 2);
      read_check("keep_100", 13'd100, 32'h100);
      read_check("keep_5", 13'd5, 32'hDEADAAAA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
